// File: rtl/camera_capture_pkg.sv
// Shared constants for the camera capture block: pairing FSM encodings and
// default parameter values.
package camera_capture_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int DEPTH_DEF     = 4;
    localparam int BURST_GAP_DEF = 7;
    localparam int THRESH_DEF    = 4;
    localparam int SKIP_HOLD_DEF = 4;

    localparam logic [1:0] WAIT_FIRST  = 2'b00;
    localparam logic [1:0] WAIT_SECOND = 2'b01;
    localparam logic [1:0] COMPARE     = 2'b10;
    localparam logic [1:0] SKIP_ST     = 2'b11;

endpackage

// File: rtl/camera_capture_fifo.sv
// Frame FIFO: DEPTH x DATA_W storage with a registered head entry.
// The head register is loaded with the incoming sample when it becomes the head.
module capture_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW:0]       count_reg;
    logic [DATA_W-1:0] head_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = head_reg;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + ONE_CNT;
                2'b01:   count_reg <= count_reg - ONE_CNT;
                default: count_reg <= count_reg;
            endcase
            // New sample becomes the head when the FIFO is (or is about to be) empty
            if (push_ok && (empty || (pop_ok && count_reg == ONE_CNT)))
                head_reg <= din;
            else if (pop_ok)
                head_reg <= mem[rd_ptr_reg + ONE_PTR];
        end
    end

endmodule

// File: rtl/camera_capture.sv
// Camera-side shutter responder: captures one sample per shutter pulse into a
// FIFO and requests a skip when the two shots of a burst are near-identical.
module camera_capture
    import camera_capture_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int BURST_GAP = BURST_GAP_DEF,
    parameter int THRESH    = THRESH_DEF,
    parameter int SKIP_HOLD = SKIP_HOLD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shutter,
    input  logic [DATA_W-1:0] pixel_in,
    output logic              skip,
    output logic              frame_valid,
    output logic [DATA_W-1:0] frame_data,
    input  logic              frame_ready,
    output logic              overflow
);
    localparam int GW = $clog2(BURST_GAP + 1);
    localparam int HW = $clog2(SKIP_HOLD + 1);
    localparam logic [GW-1:0]   GAP_ONE   = GW'(1);
    localparam logic [GW-1:0]   GAP_LAST  = GW'(BURST_GAP - 1);
    localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0]   HOLD_INIT = HW'(SKIP_HOLD - 1);
    localparam logic [DATA_W:0] THRESH_W  = (DATA_W+1)'(THRESH);

    logic              shutter_q_reg;
    logic              shot;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              overflow_reg;
    logic              skip_reg;
    logic [1:0]        state_reg,    state_next;
    logic [GW-1:0]     gap_reg,      gap_next;
    logic [HW-1:0]     hold_reg,     hold_next;
    logic [DATA_W-1:0] sample_a_reg, sample_a_next;
    logic [DATA_W-1:0] sample_b_reg, sample_b_next;
    logic [DATA_W-1:0] diff;

    assign shot        = shutter & ~shutter_q_reg;
    assign frame_valid = ~fifo_empty;
    assign pop         = frame_valid & frame_ready;
    assign skip        = skip_reg;
    assign overflow    = overflow_reg;

    capture_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (shot),
        .din   (pixel_in),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (frame_data)
    );

    assign diff = (sample_a_reg >= sample_b_reg) ? (sample_a_reg - sample_b_reg)
                                                 : (sample_b_reg - sample_a_reg);

    always_comb begin
        state_next    = state_reg;
        gap_next      = gap_reg;
        hold_next     = hold_reg;
        sample_a_next = sample_a_reg;
        sample_b_next = sample_b_reg;
        case (state_reg)
            WAIT_FIRST: begin
                if (shot) begin
                    sample_a_next = pixel_in;
                    gap_next      = '0;
                    state_next    = WAIT_SECOND;
                end
            end
            WAIT_SECOND: begin
                // gap never passes BURST_GAP-1 here, so any shot is in-window
                gap_next = gap_reg + GAP_ONE;
                if (shot) begin
                    sample_b_next = pixel_in;
                    state_next    = COMPARE;
                end else if (gap_reg == GAP_LAST) begin
                    state_next = WAIT_FIRST;
                end
            end
            COMPARE: begin
                if ({1'b0, diff} <= THRESH_W) begin
                    state_next = SKIP_ST;
                    hold_next  = HOLD_INIT;
                end else begin
                    state_next = WAIT_FIRST;
                end
            end
            SKIP_ST: begin
                if (hold_reg == '0)
                    state_next = WAIT_FIRST;
                else
                    hold_next = hold_reg - HOLD_ONE;
            end
            default: state_next = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shutter_q_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            skip_reg      <= 1'b0;
            state_reg     <= WAIT_FIRST;
            gap_reg       <= '0;
            hold_reg      <= '0;
            sample_a_reg  <= '0;
            sample_b_reg  <= '0;
        end else begin
            shutter_q_reg <= shutter;
            if (shot && fifo_full && !pop)
                overflow_reg <= 1'b1;
            skip_reg      <= (state_next == SKIP_ST);
            state_reg     <= state_next;
            gap_reg       <= gap_next;
            hold_reg      <= hold_next;
            sample_a_reg  <= sample_a_next;
            sample_b_reg  <= sample_b_next;
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture: directed scenarios plus a randomized run, checked
// against a timeline model of shots, bursts and the frame queue.
module tb_camera_capture;
    localparam int DEPTH     = 4;
    localparam int BURST_GAP = 7;
    localparam int THRESH    = 4;
    localparam int SKIP_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       shutter = 1'b0;
    logic [7:0] pixel_in = 8'h00;
    logic       frame_ready = 1'b0;
    logic       skip;
    logic       frame_valid;
    logic [7:0] frame_data;
    logic       overflow;

    always #5 clk = ~clk;

    camera_capture dut (
        .clk         (clk),
        .reset       (reset),
        .shutter     (shutter),
        .pixel_in    (pixel_in),
        .skip        (skip),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_ready (frame_ready),
        .overflow    (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame queue, sticky overflow, and burst timeline
    logic [7:0] m_q[$];
    bit         m_ovf = 0;
    bit         m_shq = 0;
    int         cyc = 0;
    bit         pend_valid = 0;
    int         pend_t = 0;
    int         pend_v = 0;
    int         busy_end = -1;
    bit         skip_at[int];
    logic [7:0] drained[$];
    logic [7:0] expv[$];

    task automatic model_edge(input logic r, input logic sh, input logic [7:0] px, input logic rdy);
        bit shot;
        bit popd;
        int sz;
        int d;
        if (!r) begin
            m_q.delete();
            m_ovf = 0;
            m_shq = 0;
            pend_valid = 0;
            busy_end = -1;
            skip_at.delete();
        end else begin
            shot = sh && !m_shq;
            sz   = m_q.size();
            popd = (sz > 0) && rdy;
            if (popd) void'(m_q.pop_front());
            if (shot) begin
                if (sz < DEPTH || popd) m_q.push_back(px);
                else m_ovf = 1;
            end
            if (shot && cyc > busy_end) begin
                if (pend_valid && (cyc - pend_t) <= BURST_GAP) begin
                    d = (pend_v > int'(px)) ? pend_v - int'(px) : int'(px) - pend_v;
                    pend_valid = 0;
                    if (d <= THRESH) begin
                        for (int k = 2; k <= SKIP_HOLD + 1; k++) skip_at[cyc + k] = 1;
                        busy_end = cyc + 1 + SKIP_HOLD;
                    end else begin
                        busy_end = cyc + 1;
                    end
                end else begin
                    pend_valid = 1;
                    pend_t = cyc;
                    pend_v = int'(px);
                end
            end
            m_shq = sh;
        end
        cyc++;
    endtask

    function automatic bit exp_skip();
        return skip_at.exists(cyc);
    endfunction

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge
    task automatic cycle(input logic r, input logic sh, input logic [7:0] px, input logic rdy);
        reset = r;
        shutter = sh;
        pixel_in = px;
        frame_ready = rdy;
        @(posedge clk);
        model_edge(r, sh, px, rdy);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        drained.delete();
        for (int i = 0; i < DEPTH + 2 && frame_valid; i++) begin
            drained.push_back(frame_data);
            cycle(1'b1, 1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b1, 8'h11, 1'b1);
        cycle(1'b0, 1'b0, 8'h22, 1'b1);
        n_tests++; if (skip !== 1'b0) begin n_fail++; $display("FAIL reset_skip got=%b exp=0", skip); end
        n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_tests++; if (frame_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", frame_data); end
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_nocapture got=%b exp=0", frame_valid); end
        $display("[TB] test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_near_pair();
        int sk = 0;
        cycle(1'b1, 1'b1, 8'h40, 1'b0);
        idle(2);
        cycle(1'b1, 1'b1, 8'h42, 1'b0);
        for (int i = 0; i < 8; i++) begin
            // cycles t1+4 .. t1+11; skip expected in t1+5 .. t1+8
            n_tests++;
            if (skip !== ((i >= 1 && i <= 4) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL near_skip t1+%0d got=%b exp=%b", i + 4, skip, (i >= 1 && i <= 4));
            end
            sk += int'(skip);
            idle(1);
        end
        n_tests++; if (sk != SKIP_HOLD) begin n_fail++; $display("FAIL near_skip_len got=%0d exp=%0d", sk, SKIP_HOLD); end
        drain();
        expv.delete(); expv.push_back(8'h40); expv.push_back(8'h42);
        n_tests++; if (drained.size() != expv.size()) begin n_fail++; $display("FAIL near_count got=%0d exp=%0d", drained.size(), expv.size()); end
        for (int i = 0; i < expv.size() && i < drained.size(); i++) begin
            n_tests++; if (drained[i] !== expv[i]) begin n_fail++; $display("FAIL near_data[%0d] got=%h exp=%h", i, drained[i], expv[i]); end
        end
        $display("[TB] test_near_pair done: skip cycles=%0d drained=%0d", sk, drained.size());
    endtask

    task automatic test_far_pair();
        int sk = 0;
        cycle(1'b1, 1'b1, 8'h10, 1'b0);
        idle(2);
        cycle(1'b1, 1'b1, 8'h80, 1'b0);
        for (int i = 0; i < 8; i++) begin sk += int'(skip); idle(1); end
        n_tests++; if (sk != 0) begin n_fail++; $display("FAIL far_skip got=%0d exp=0", sk); end
        drain();
        expv.delete(); expv.push_back(8'h10); expv.push_back(8'h80);
        n_tests++; if (drained.size() != expv.size()) begin n_fail++; $display("FAIL far_count got=%0d exp=%0d", drained.size(), expv.size()); end
        for (int i = 0; i < expv.size() && i < drained.size(); i++) begin
            n_tests++; if (drained[i] !== expv[i]) begin n_fail++; $display("FAIL far_data[%0d] got=%h exp=%h", i, drained[i], expv[i]); end
        end
        $display("[TB] test_far_pair done: skip cycles=%0d drained=%0d", sk, drained.size());
    endtask

    task automatic test_timeout();
        int sk_lone = 0;
        int sk_pair = 0;
        cycle(1'b1, 1'b1, 8'h20, 1'b0);
        for (int i = 0; i < 10; i++) begin sk_lone += int'(skip); idle(1); end
        cycle(1'b1, 1'b1, 8'h21, 1'b0);
        idle(2);
        cycle(1'b1, 1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 8; i++) begin sk_pair += int'(skip); idle(1); end
        n_tests++; if (sk_lone != 0) begin n_fail++; $display("FAIL timeout_lone_skip got=%0d exp=0", sk_lone); end
        n_tests++; if (sk_pair != SKIP_HOLD) begin n_fail++; $display("FAIL timeout_pair_skip got=%0d exp=%0d", sk_pair, SKIP_HOLD); end
        drain();
        expv.delete(); expv.push_back(8'h20); expv.push_back(8'h21); expv.push_back(8'h22);
        n_tests++; if (drained.size() != expv.size()) begin n_fail++; $display("FAIL timeout_count got=%0d exp=%0d", drained.size(), expv.size()); end
        for (int i = 0; i < expv.size() && i < drained.size(); i++) begin
            n_tests++; if (drained[i] !== expv[i]) begin n_fail++; $display("FAIL timeout_data[%0d] got=%h exp=%h", i, drained[i], expv[i]); end
        end
        $display("[TB] test_timeout done: lone skip=%0d pair skip=%0d", sk_lone, sk_pair);
    endtask

    task automatic test_overflow();
        for (int v = 1; v <= 5; v++) begin
            cycle(1'b1, 1'b1, 8'(v), 1'b0);
            n_tests++;
            if (overflow !== ((v == 5) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL overflow_after_shot%0d got=%b exp=%b", v, overflow, (v == 5));
            end
            idle(8);
        end
        drain();
        expv.delete(); for (int v = 1; v <= 4; v++) expv.push_back(8'(v));
        n_tests++; if (drained.size() != expv.size()) begin n_fail++; $display("FAIL overflow_count got=%0d exp=%0d", drained.size(), expv.size()); end
        for (int i = 0; i < expv.size() && i < drained.size(); i++) begin
            n_tests++; if (drained[i] !== expv[i]) begin n_fail++; $display("FAIL overflow_data[%0d] got=%h exp=%h", i, drained[i], expv[i]); end
        end
        n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL overflow_empty got=%b exp=0", frame_valid); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
        $display("[TB] test_overflow done: drained=%0d overflow=%b", drained.size(), overflow);
    endtask

    task automatic test_held_and_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 8'h55, 1'b0);
        idle(10);
        drain();
        n_tests++; if (drained.size() != 1) begin n_fail++; $display("FAIL held_count got=%0d exp=1", drained.size()); end
        n_tests++; if (drained.size() > 0 && drained[0] !== 8'h55) begin n_fail++; $display("FAIL held_data got=%h exp=55", drained[0]); end
        idle(2);
        cycle(1'b1, 1'b1, 8'h30, 1'b0);
        idle(2);
        cycle(1'b1, 1'b1, 8'h31, 1'b0);
        idle(2);
        // now in the second skip cycle
        n_tests++; if (skip !== 1'b1) begin n_fail++; $display("FAIL midskip_active got=%b exp=1", skip); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL midskip_ovf_before got=%b exp=1", overflow); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        n_tests++; if (skip !== 1'b0) begin n_fail++; $display("FAIL midskip_skip got=%b exp=0", skip); end
        n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL midskip_valid got=%b exp=0", frame_valid); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midskip_ovf got=%b exp=0", overflow); end
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        $display("[TB] test_held_and_reset done at cycle %0d", cyc);
    endtask

    task automatic test_random();
        logic       r;
        logic       sh;
        logic [7:0] px;
        logic       rdy;
        int         skips = 0;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 149) != 0);
            sh  = ($urandom_range(0, 2) == 0);
            px  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(16, 28));
            rdy = ($urandom_range(0, 3) == 0);
            cycle(r, sh, px, rdy);
            skips += int'(skip);
            n_tests++; if (skip !== exp_skip()) begin n_fail++; $display("FAIL rand_skip cyc=%0d got=%b exp=%b", cyc, skip, exp_skip()); end
            n_tests++; if (frame_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, frame_valid, (m_q.size() > 0)); end
            n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf); end
            if (m_q.size() > 0) begin
                n_tests++; if (frame_data !== m_q[0]) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, frame_data, m_q[0]); end
            end
        end
        $display("[TB] test_random done: skip cycles=%0d", skips);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_near_pair();
        test_far_pair();
        test_timeout();
        test_overflow();
        test_held_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
